game_sequencer: RTL and testbench

//  Turn-by-turn controller for the tic-tac-toe board memory (memArray).
//  - Clears the board at game start and accepts player moves.
//  - Rejects illegal moves, then writes each legal move into the board.
//  - Evaluates the board after every write, alternates turns and enforces an optional turn timeout.
//  - Sits between the player-input logic and memArray: drives memArray addr/cellState, reads back gameBoard.

---
 rtl/ttt_pkg.sv | 40 ++++
 rtl/win_check.sv | 47 ++++
 rtl/game_sequencer.sv | 159 +++++++++++++++
 tb/tb_game_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
// Cell write/readback encodings, result codes and FSM states.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b11,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    NOWIN = 2'b00,
    TIE   = 2'b01,
    P2WIN = 2'b10,
    P1WIN = 2'b11
  } result_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT,
    WRITE,
    EVAL,
    DONE
  } state_t;

  localparam int         NUM_CELLS = 9;
  localparam logic [3:0] ADDR_NONE = 4'hF;

  // Readback code of cell i; callers keep i within 0..8.
  function automatic logic [1:0] cell_at(
    input logic [17:0] b,
    input logic [3:0]  i
  );
    logic [17:0] s;
    s = b >> {i, 1'b0};
    return s[1:0];
  endfunction

endpackage

// File: rtl/win_check.sv
// Combinational line decoder over the memArray readback.
// Readback encoding: 11 = player1, 01 = player2.
module win_check
  import ttt_pkg::*;
(
  input  logic [17:0] gameBoard,
  output result_t     winner
);

  // Each entry packs three cell indices of one line.
  localparam logic [11:0] LINES [8] = '{
    {4'd0, 4'd1, 4'd2},
    {4'd3, 4'd4, 4'd5},
    {4'd6, 4'd7, 4'd8},
    {4'd0, 4'd3, 4'd6},
    {4'd1, 4'd4, 4'd7},
    {4'd2, 4'd5, 4'd8},
    {4'd0, 4'd4, 4'd8},
    {4'd2, 4'd4, 4'd6}
  };

  function automatic logic line_is(
    input logic [17:0] b,
    input logic [11:0] ln,
    input logic [1:0]  v
  );
    return cell_at(b, ln[11:8]) == v &&
           cell_at(b, ln[7:4])  == v &&
           cell_at(b, ln[3:0])  == v;
  endfunction

  logic p1_line;
  logic p2_line;

  always_comb begin
    p1_line = 1'b0;
    p2_line = 1'b0;
    for (int l = 0; l < 8; l++) begin
      p1_line = p1_line | line_is(gameBoard, LINES[l], 2'b11);
      p2_line = p2_line | line_is(gameBoard, LINES[l], 2'b01);
    end
  end

  assign winner = p1_line ? P1WIN :
                  p2_line ? P2WIN : NOWIN;

endmodule

// File: rtl/game_sequencer.sv
// Turn-by-turn controller for the tic-tac-toe board memory.
// Clears the board, validates and writes moves, scores and times turns.
module game_sequencer
  import ttt_pkg::*;
#(
  parameter int TURN_TIMEOUT = 0,
  parameter int TIMEOUT_W    = 16
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        start,
  input  logic        moveReq,
  input  logic [3:0]  moveAddr,
  input  logic [17:0] gameBoard,
  output logic [3:0]  addr,
  output logic [1:0]  cellState,
  output logic        moveAck,
  output logic        moveErr,
  output logic        turn,
  output logic [3:0]  moveCount,
  output logic [1:0]  result,
  output logic        busy
);

  localparam logic [TIMEOUT_W-1:0] T_LAST =
    TIMEOUT_W'(TURN_TIMEOUT - 1);

  state_t               state, state_n;
  logic [3:0]           clr_idx, clr_idx_n;
  logic [TIMEOUT_W-1:0] timer, timer_n;
  logic                 turn_n;
  logic [3:0]           count_n, count_inc;
  result_t              res_q, res_n, winner;
  logic [3:0]           wr_addr, wr_addr_n;

  logic timed_out;
  logic illegal;
  logic go_to, go_err, go_ack;

  win_check u_win (
    .gameBoard (gameBoard),
    .winner    (winner)
  );

  assign result    = res_q;
  assign count_inc = moveCount + 4'd1;
  assign timed_out = (TURN_TIMEOUT != 0) && (timer == T_LAST);
  assign illegal   = (moveAddr > 4'd8) ||
                     (cell_at(gameBoard, moveAddr) != 2'b00);

  // start beats timeout beats moveReq
  assign go_to  = !start && timed_out;
  assign go_err = !start && !timed_out && moveReq && illegal;
  assign go_ack = !start && !timed_out && moveReq && !illegal;

  always_comb begin
    state_n   = state;
    clr_idx_n = clr_idx;
    timer_n   = timer;
    turn_n    = turn;
    count_n   = moveCount;
    res_n     = res_q;
    wr_addr_n = wr_addr;
    addr      = ADDR_NONE;
    cellState = EMPTY;
    moveAck   = 1'b0;
    moveErr   = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = CLEAR;
          clr_idx_n = 4'd0;
        end
      end
      CLEAR: begin
        busy      = 1'b1;
        addr      = clr_idx;
        clr_idx_n = clr_idx + 4'd1;
        if (clr_idx == 4'(NUM_CELLS - 1)) begin
          state_n = WAIT;
          turn_n  = 1'b0;
          count_n = 4'd0;
          res_n   = NOWIN;
          timer_n = '0;
        end
      end
      WAIT: begin
        timer_n = timer + 1'b1;
        unique case (1'b1)
          start: begin
            state_n   = CLEAR;
            clr_idx_n = 4'd0;
          end
          go_to: begin
            res_n   = turn ? P1WIN : P2WIN;
            state_n = DONE;
          end
          go_err: moveErr = 1'b1;
          go_ack: begin
            moveAck   = 1'b1;
            wr_addr_n = moveAddr;
            state_n   = WRITE;
          end
          default: ;
        endcase
      end
      WRITE: begin
        busy      = 1'b1;
        addr      = wr_addr;
        cellState = turn ? P2 : P1;
        state_n   = EVAL;
      end
      EVAL: begin
        busy    = 1'b1;
        count_n = count_inc;
        if (winner != NOWIN) begin
          res_n   = winner;
          state_n = DONE;
        end else if (count_inc == 4'(NUM_CELLS)) begin
          res_n   = TIE;
          state_n = DONE;
        end else begin
          turn_n  = ~turn;
          timer_n = '0;
          state_n = WAIT;
        end
      end
      DONE: begin
        if (start) begin
          state_n   = CLEAR;
          clr_idx_n = 4'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      clr_idx   <= 4'd0;
      timer     <= '0;
      turn      <= 1'b0;
      moveCount <= 4'd0;
      res_q     <= NOWIN;
      wr_addr   <= ADDR_NONE;
    end else begin
      state     <= state_n;
      clr_idx   <= clr_idx_n;
      timer     <= timer_n;
      turn      <= turn_n;
      moveCount <= count_n;
      res_q     <= res_n;
      wr_addr   <= wr_addr_n;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer with a behavioural memArray.
// Expected writes and ack/err pulses are queued at drive time.
module tb_game_sequencer;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        start;
  logic        moveReq;
  logic [3:0]  moveAddr;
  logic [17:0] gameBoard;
  logic [3:0]  addr;
  logic [1:0]  cellState;
  logic        moveAck;
  logic        moveErr;
  logic        turn;
  logic [3:0]  moveCount;
  logic [1:0]  result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [5:0] wq[$];
  logic [1:0] rq[$];

  logic       exp_turn;
  logic [3:0] exp_cnt;

  game_sequencer #(
    .TURN_TIMEOUT (20),
    .TIMEOUT_W    (16)
  ) dut (
    .ph1       (ph1),
    .reset     (reset),
    .start     (start),
    .moveReq   (moveReq),
    .moveAddr  (moveAddr),
    .gameBoard (gameBoard),
    .addr      (addr),
    .cellState (cellState),
    .moveAck   (moveAck),
    .moveErr   (moveErr),
    .turn      (turn),
    .moveCount (moveCount),
    .result    (result),
    .busy      (busy)
  );

  always #5 ph1 = ~ph1;

  // memArray: writes 11 -> 11, 10 -> 01, 00 -> 00 at readback
  initial gameBoard = '0;
  always @(posedge ph1) begin
    if (addr < 4'd9)
      gameBoard[int'(addr) * 2 +: 2] <=
        (cellState == 2'b11) ? 2'b11 :
        (cellState == 2'b10) ? 2'b01 : 2'b00;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge ph1) begin
    if (addr != 4'hF) begin
      if (wq.size() == 0) chk("spurious_wr", 32'(addr), 32'hF);
      else chk("wr", 32'({addr, cellState}), 32'(wq.pop_front()));
    end
    if (moveAck || moveErr) begin
      if (rq.size() == 0)
        chk("spurious_resp", 32'({moveAck, moveErr}), 0);
      else
        chk("resp", 32'({moveAck, moveErr}), 32'(rq.pop_front()));
    end
  end

  task automatic tick;
    @(posedge ph1);
    #1;
  endtask

  task automatic new_game;
    for (int i = 0; i < 9; i++) wq.push_back({4'(i), 2'b00});
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("clr_busy", 32'(busy), 1);
    repeat (9) tick;
    chk("wait_busy", 32'(busy), 0);
    chk("wait_turn", 32'(turn), 0);
    chk("wait_cnt", 32'(moveCount), 0);
    chk("wait_res", 32'(result), 0);
    chk("wait_addr", 32'(addr), 32'hF);
    exp_turn = 1'b0;
    exp_cnt  = 4'd0;
  endtask

  task automatic do_move(
    input logic [3:0] a,
    input bit         legal,
    input logic [1:0] exp_res
  );
    moveReq  = 1'b1;
    moveAddr = a;
    if (legal) begin
      rq.push_back(2'b10);
      wq.push_back({a, exp_turn ? 2'b10 : 2'b11});
      tick;
      moveReq = 1'b0;
      chk("wr_busy", 32'(busy), 1);
      tick;
      tick;
      exp_cnt++;
      if (exp_res == 2'b00) exp_turn = ~exp_turn;
      chk("mv_res", 32'(result), 32'(exp_res));
    end else begin
      rq.push_back(2'b01);
      tick;
      moveReq = 1'b0;
    end
    chk("mv_cnt", 32'(moveCount), 32'(exp_cnt));
    chk("mv_turn", 32'(turn), 32'(exp_turn));
  endtask

  task automatic done_ignores;
    logic [1:0] r;
    r = result;
    moveReq  = 1'b1;
    moveAddr = 4'd4;
    #1;
    chk("done_ack", 32'(moveAck), 0);
    chk("done_err", 32'(moveErr), 0);
    tick;
    moveReq = 1'b0;
    chk("done_hold", 32'(result), 32'(r));
    chk("done_cnt", 32'(moveCount), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    moveReq  = 1'b0;
    moveAddr = 4'd0;
    exp_turn = 1'b0;
    exp_cnt  = 4'd0;
    repeat (3) @(posedge ph1);
    #1;
    chk("rst_addr", 32'(addr), 32'hF);
    chk("rst_cell", 32'(cellState), 0);
    chk("rst_turn", 32'(turn), 0);
    chk("rst_cnt", 32'(moveCount), 0);
    chk("rst_res", 32'(result), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    tick;
    chk("idle_busy", 32'(busy), 0);

    // P1 wins on top row
    new_game;
    do_move(4'd0, 1, 2'b00);
    do_move(4'd3, 1, 2'b00);
    do_move(4'd1, 1, 2'b00);
    do_move(4'd4, 1, 2'b00);
    do_move(4'd2, 1, 2'b11);
    chk("win_cnt", 32'(moveCount), 5);
    done_ignores;

    // occupied cell, then out-of-range addresses
    new_game;
    do_move(4'd4, 1, 2'b00);
    do_move(4'd4, 0, 2'b00);
    do_move(4'd9, 0, 2'b00);
    do_move(4'd15, 0, 2'b00);
    do_move(4'd8, 1, 2'b00);

    // drawn game
    new_game;
    do_move(4'd0, 1, 2'b00);
    do_move(4'd1, 1, 2'b00);
    do_move(4'd2, 1, 2'b00);
    do_move(4'd4, 1, 2'b00);
    do_move(4'd3, 1, 2'b00);
    do_move(4'd5, 1, 2'b00);
    do_move(4'd7, 1, 2'b00);
    do_move(4'd6, 1, 2'b00);
    do_move(4'd8, 1, 2'b01);
    chk("tie_cnt", 32'(moveCount), 9);
    done_ignores;

    // ninth move completes a column: win, not tie
    new_game;
    do_move(4'd0, 1, 2'b00);
    do_move(4'd1, 1, 2'b00);
    do_move(4'd2, 1, 2'b00);
    do_move(4'd4, 1, 2'b00);
    do_move(4'd3, 1, 2'b00);
    do_move(4'd5, 1, 2'b00);
    do_move(4'd7, 1, 2'b00);
    do_move(4'd8, 1, 2'b00);
    do_move(4'd6, 1, 2'b11);

    // P1 idles for the full turn budget
    new_game;
    repeat (19) tick;
    chk("to_pre_res", 32'(result), 0);
    chk("to_pre_busy", 32'(busy), 0);
    tick;
    chk("to_res", 32'(result), 32'h2);
    done_ignores;
    new_game;

    // reset in the middle of a game
    do_move(4'd0, 1, 2'b00);
    reset = 1'b0;
    #1;
    chk("mid_rst_turn", 32'(turn), 0);
    chk("mid_rst_cnt", 32'(moveCount), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    tick;
    reset = 1'b1;
    tick;
    chk("mid_rst_addr", 32'(addr), 32'hF);

    tick;
    chk("wq_left", 32'(wq.size()), 0);
    chk("rq_left", 32'(rq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
